// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, owner encoding and default widths for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_e;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_IF_WAIT = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int STARVE_W        = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory req/gnt/rvalid buses; slave = arbiter view, master = core/memory view
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_prio_sel.sv
// mem_arb_prio_sel: data-first winner select with a fetch starvation counter
module mem_arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_IF_WAIT = DEF_MAX_IF_WAIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic                d_req,
  input  logic                accept,
  output logic                sel_d,
  output logic [STARVE_W-1:0] cnt
);
  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(MAX_IF_WAIT);
  logic [STARVE_W-1:0] cnt_q, cnt_d;
  assign sel_d = d_req && !(if_req && cnt_q == CNT_MAX);
  assign cnt   = cnt_q;
  // Count D grants taken while fetch waits; any IF grant or idle fetch clears it.
  always_comb
    cnt_d = !if_req            ? '0 :
            !accept            ? cnt_q :
            !sel_d             ? '0 :
            (cnt_q == CNT_MAX) ? cnt_q : cnt_q + STARVE_W'(1);
  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, one transaction in flight.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_IF_WAIT = DEF_MAX_IF_WAIT
`ifdef ARB_PERF_CNT_EN
  ,
  parameter int CNT_W       = DEF_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic              busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_if_gnt,
  output logic [CNT_W-1:0]  perf_d_gnt,
  output logic [CNT_W-1:0]  perf_stall
`endif
);
  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic                we_q, we_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                accept, sel_d, if_gnt, d_gnt, rsp, if_rv, d_rv;
  logic [STARVE_W-1:0] unused_starve_cnt;

  mem_arb_prio_sel #(.MAX_IF_WAIT(MAX_IF_WAIT)) u_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .accept (accept),
    .sel_d  (sel_d),
    .cnt    (unused_starve_cnt)
  );

  // Next state; in IDLE accept the winner and latch its fields (fetches read a full word).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        accept = rst_n && (bus.if_req || bus.d_req);
        if (accept) begin
          state_d = REQ;
          owner_d = sel_d ? OWN_D : OWN_IF;
          we_d    = sel_d && bus.d_we;
          be_d    = sel_d ? bus.d_be : '1;
          addr_d  = sel_d ? bus.d_addr : bus.if_addr;
          wdata_d = sel_d ? bus.d_wdata : '0;
        end
      end
      REQ:     state_d = bus.mem_gnt ? RESP : REQ;
      RESP:    state_d = bus.mem_rvalid ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, owner and latched request fields.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end

  assign if_gnt = accept && !sel_d;
  assign d_gnt  = accept && sel_d;
  assign rsp    = (state_q == RESP) && bus.mem_rvalid;
  assign if_rv  = rsp && owner_q == OWN_IF;
  assign d_rv   = rsp && owner_q == OWN_D;

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rv;
  assign bus.d_rvalid  = d_rv;
  assign bus.if_rdata  = if_rv ? bus.mem_rdata : '0;
  assign bus.d_rdata   = d_rv ? bus.mem_rdata : '0;
  assign bus.mem_req   = state_q == REQ;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = state_q != IDLE;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] perf_if_gnt_q, perf_if_gnt_d;
  logic [CNT_W-1:0] perf_d_gnt_q, perf_d_gnt_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic             stall;
  assign stall = (bus.if_req || bus.d_req) && !(if_gnt || d_gnt);
  // Saturating event counters.
  always_comb begin
    perf_if_gnt_d = (if_gnt && !(&perf_if_gnt_q)) ? perf_if_gnt_q + CNT_W'(1) : perf_if_gnt_q;
    perf_d_gnt_d  = (d_gnt && !(&perf_d_gnt_q)) ? perf_d_gnt_q + CNT_W'(1) : perf_d_gnt_q;
    perf_stall_d  = (stall && !(&perf_stall_q)) ? perf_stall_q + CNT_W'(1) : perf_stall_q;
  end
  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_if_gnt_q <= '0;
      perf_d_gnt_q  <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_if_gnt_q <= perf_if_gnt_d;
      perf_d_gnt_q  <= perf_d_gnt_d;
      perf_stall_q  <= perf_stall_d;
    end
  assign perf_if_gnt = perf_if_gnt_q;
  assign perf_d_gnt  = perf_d_gnt_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a rule-level model
module tb_mem_port_arbiter;
  localparam int MAX_IF_WAIT = 4;
  logic clk, rst_n, busy;
  int checks, errors, streak, ifg, dg, stall_m;
  logic g, oi, od, cur_if, cur_d;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_if_gnt, perf_d_gnt, perf_stall;
`endif

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_IF_WAIT(MAX_IF_WAIT)
`ifdef ARB_PERF_CNT_EN
    , .CNT_W(16)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_gnt(perf_if_gnt), .perf_d_gnt(perf_d_gnt), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from the accept cycle to the first IDLE cycle after the response.
  // nif/nd are the owner's next request level; the loser keeps holding its request.
  task automatic txn(input logic ir, dr, nif, nd, input int gd, rd, input logic we,
                     input logic [3:0] be, input logic [31:0] ia, da, wd, rdat,
                     output logic got_d, output logic oir, output logic odr);
    logic win_d;
    logic [31:0] ea;
    bus.if_req = ir; bus.if_addr = ia;
    bus.d_req = dr; bus.d_we = we; bus.d_be = be; bus.d_addr = da; bus.d_wdata = wd;
    #1;
    win_d = dr && !(ir && streak == MAX_IF_WAIT);
    chk("if_gnt", bus.if_gnt, ir && !win_d);
    chk("d_gnt", bus.d_gnt, win_d);
    got_d = bus.d_gnt;
    if (!ir) streak = 0;
    else if (win_d) streak = (streak == MAX_IF_WAIT) ? MAX_IF_WAIT : streak + 1;
    else streak = 0;
    if (win_d) dg++; else ifg++;
    oir = win_d ? ir : nif;
    odr = win_d ? nd : dr;
    if (!oir) streak = 0;
    if (oir || odr) stall_m += gd + rd + 1;
    ea = win_d ? da : ia;
    for (int c = 0; c < gd + rd + 1; c++) begin
      tick();
      bus.if_req = oir; bus.d_req = odr;
      bus.if_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = $urandom;
      bus.d_we = 1'($urandom); bus.d_be = 4'($urandom);
      bus.mem_gnt = (c == gd) ? 1'b1 : (c > gd) ? 1'($urandom) : 1'b0;
      bus.mem_rvalid = (c == gd + rd) ? 1'b1 : (c <= gd) ? 1'($urandom) : 1'b0;
      bus.mem_rdata = (c == gd + rd) ? rdat : $urandom;
      #1;
      chk("busy_in_txn", busy, 1);
      chk("no_if_gnt_busy", bus.if_gnt, 0);
      chk("no_d_gnt_busy", bus.d_gnt, 0);
      if (c <= gd) begin
        chk("mem_req", bus.mem_req, 1);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_we", bus.mem_we, win_d && we);
        if (win_d) begin
          chk("mem_be", bus.mem_be, be);
          chk("mem_wdata", bus.mem_wdata, wd);
        end
      end else chk("mem_req_resp", bus.mem_req, 0);
      chk("if_rvalid", bus.if_rvalid, c == gd + rd && !win_d);
      chk("d_rvalid", bus.d_rvalid, c == gd + rd && win_d);
      chk("if_rdata", bus.if_rdata, (c == gd + rd && !win_d) ? rdat : 32'h0);
      chk("d_rdata", bus.d_rdata, (c == gd + rd && win_d) ? rdat : 32'h0);
    end
    tick();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    #1;
    chk("idle_after_txn", busy, 0);
  endtask

  initial begin
    checks = 0; errors = 0; streak = 0; ifg = 0; dg = 0; stall_m = 0;
    rst_n = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h44; bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
    bus.d_addr = 32'h88; bus.d_wdata = 32'h1234; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_d_gnt", bus.d_gnt, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    txn(1, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0000_0010, 32'h0, 32'h0, 32'h0050_0093, g, oi, od);
    txn(1, 1, 0, 0, 0, 1, 0, 4'hF, 32'h40, 32'h100, 32'h0, 32'hCAFE_0001, g, oi, od);
    chk("simul_d_first", g, 1);
    txn(oi, od, 0, 0, 0, 1, 0, 4'hF, 32'h44, 32'h0, 32'h0, 32'hCAFE_0002, g, oi, od);
    chk("simul_if_second", g, 0);
    txn(0, 1, 0, 0, 3, 2, 1, 4'h3, 32'h0, 32'h204, 32'hDEAD_BEEF, 32'h5555_AAAA, g, oi, od);
    chk("store_owner_d", g, 1);
    for (int i = 0; i < 10; i++) begin
      txn(1, 1, 1, 1, $urandom_range(0, 2), $urandom_range(1, 2), 1'($urandom), 4'($urandom),
          $urandom, $urandom, $urandom, $urandom, g, oi, od);
      chk("starve_order", g, (i % 5) != 4);
    end
    cur_if = oi; cur_d = od;
    repeat (40) begin
      cur_if = cur_if | 1'($urandom);
      cur_d  = cur_d | 1'($urandom);
      if (!cur_if && !cur_d) begin
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        bus.mem_gnt = 1'($urandom); bus.mem_rvalid = 1'($urandom);
        #1;
        chk("idle_no_gnt", bus.if_gnt | bus.d_gnt, 0);
        chk("idle_no_rvalid", bus.if_rvalid | bus.d_rvalid, 0);
        tick();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        streak = 0;
        #1;
        chk("idle_stays_idle", busy, 0);
      end else
        txn(cur_if, cur_d, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(1, 3),
            1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom, g, cur_if, cur_d);
    end
    while (cur_if || cur_d)
      txn(cur_if, cur_d, 0, 0, 0, 1, 0, 4'hF, $urandom, $urandom, $urandom, $urandom, g, cur_if, cur_d);
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    #1;
    chk("mid_rst_accept", bus.if_gnt, 1);
    tick();
    bus.if_req = 1'b0; bus.mem_gnt = 1'b1;
    #1;
    chk("mid_rst_req", bus.mem_req, 1);
    tick();
    bus.mem_gnt = 1'b0;
    #1;
    chk("mid_rst_in_resp", busy, 1);
    rst_n = 1'b0; bus.if_req = 1'b1; bus.d_req = 1'b1; bus.mem_gnt = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, 0);
    chk("mid_rst_gnts", bus.if_gnt | bus.d_gnt, 0);
    chk("mid_rst_rvalids", bus.if_rvalid | bus.d_rvalid, 0);
    tick();
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_gnt = 1'b0;
    rst_n = 1'b1;
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("stale_if_rvalid", bus.if_rvalid, 0);
    chk("stale_d_rvalid", bus.d_rvalid, 0);
    chk("stale_if_rdata", bus.if_rdata, 0);
    chk("stale_busy", busy, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("post_stale_idle", busy, 0);
    streak = 0;
`ifdef ARB_PERF_CNT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    streak = 0; ifg = 0; dg = 0; stall_m = 0;
    txn(1, 1, 1, 1, $urandom_range(0, 2), $urandom_range(1, 2), 0, 4'hF, 32'h0, 32'h300, 32'h0, $urandom, g, oi, od);
    txn(oi, od, 1, 1, $urandom_range(0, 2), $urandom_range(1, 2), 1, 4'h1, 32'h0, 32'h304, 32'h7, $urandom, g, oi, od);
    txn(oi, od, 1, 0, $urandom_range(0, 2), $urandom_range(1, 2), 0, 4'hF, 32'h0, 32'h308, 32'h0, $urandom, g, oi, od);
    for (int i = 0; i < 5; i++)
      txn(oi, od, i < 4, 0, $urandom_range(0, 2), $urandom_range(1, 2), 0, 4'hF, 32'h400 + 4 * i, 32'h0, 32'h0, $urandom, g, oi, od);
    chk("perf_if_gnt", perf_if_gnt, 5);
    chk("perf_d_gnt", perf_d_gnt, 3);
    chk("perf_stall", perf_stall, stall_m);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
